// File: rtl/mem_rd_wr_arbiter.sv
// Arbiter that shares one MIG user-interface command/write-data port between
// the capture write path and the host readout path. Bounded-burst round-robin
// on contention, one command per grant, req/ack handshake toward requesters.
module mem_rd_wr_arbiter #(
    parameter int ADDR_W     = 29,
    parameter int DATA_W     = 256,
    parameter int MAX_BURSTS = 8
) (
    input  logic                clk,
    input  logic                reset_clk_n,
    input  logic                mem_wr_req,
    input  logic [ADDR_W-1:0]   mem_wr_addr,
    input  logic [DATA_W-1:0]   mem_wr_data,
    output logic                mem_wr_ack,
    input  logic                mem_rd_req,
    input  logic [ADDR_W-1:0]   mem_rd_addr,
    output logic                mem_rd_ack,
    output logic                app_en,
    output logic [2:0]          app_cmd,
    output logic [ADDR_W-1:0]   app_addr,
    input  logic                app_rdy,
    output logic                app_wdf_wren,
    output logic [DATA_W-1:0]   app_wdf_data,
    output logic                app_wdf_end,
    output logic [DATA_W/8-1:0] app_wdf_mask,
    input  logic                app_wdf_rdy,
    output logic [1:0]          grant
);

    typedef enum logic [1:0] {ARB, WR_CMD, RD_CMD, ACK} state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_BURSTS);
    localparam logic [2:0] CMD_WR  = 3'b000;
    localparam logic [2:0] CMD_RD  = 3'b001;

    state_t     state, state_d;
    logic [7:0] burst_cnt;   // consecutive grants to last owner; 0 = no burst running
    logic       last_wr;     // 1: last owner was write, 0: read
    logic       cmd_done;    // command handshake of current write finished
    logic       data_done;   // data handshake of current write finished
    logic       take_wr;
    logic       take_rd;
    logic       keep_owner;
    logic       cmd_fire;
    logic       data_fire;

    // Port-facing strobes are decoded from registered state only, so an async
    // reset clears them in the same cycle and they never glitch on inputs.
    assign app_en       = ((state == WR_CMD) && !cmd_done) || (state == RD_CMD);
    assign app_wdf_wren = (state == WR_CMD) && !data_done;
    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_mask = '0;
    assign mem_wr_ack   = (state == ACK) && grant[1];
    assign mem_rd_ack   = (state == ACK) && grant[0];

    assign cmd_fire  = app_en & app_rdy;
    assign data_fire = app_wdf_wren & app_wdf_rdy;

    // A burst with count 0 (fresh from reset or after an idle ARB) hands the
    // tie to the other side, so reset with last owner = read favours write.
    assign keep_owner = (burst_cnt != 8'd0) && (burst_cnt < MAX_CNT);

    // Next-state and grant decision.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state;
        take_wr = 1'b0;
        take_rd = 1'b0;
        unique case (state)
            ARB: begin
                if (mem_wr_req && mem_rd_req) begin
                    take_wr = keep_owner ? last_wr : !last_wr;
                    take_rd = !take_wr;
                end else begin
                    take_wr = mem_wr_req;
                    take_rd = mem_rd_req;
                end
                if (take_wr)      state_d = WR_CMD;
                else if (take_rd) state_d = RD_CMD;
            end
            WR_CMD: begin
                if ((cmd_done || cmd_fire) && (data_done || data_fire)) state_d = ACK;
            end
            RD_CMD: begin
                if (app_rdy) state_d = ACK;
            end
            ACK:     state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_clk_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_clk_n) state <= ARB;
        else              state <= state_d;
    end

    // Command capture, burst accounting and handshake bookkeeping.
    always_ff @(posedge clk or negedge reset_clk_n) begin
        if (!reset_clk_n) begin
            app_addr     <= '0;
            app_cmd      <= CMD_WR;
            app_wdf_data <= '0;
            grant        <= 2'b00;
            burst_cnt    <= 8'd0;
            last_wr      <= 1'b0;
            cmd_done     <= 1'b0;
            data_done    <= 1'b0;
        end else begin
            if (state == ARB) begin
                if (take_wr || take_rd) begin
                    app_addr  <= take_wr ? mem_wr_addr : mem_rd_addr;
                    app_cmd   <= take_wr ? CMD_WR : CMD_RD;
                    grant     <= {take_wr, take_rd};
                    last_wr   <= take_wr;
                    cmd_done  <= 1'b0;
                    data_done <= 1'b0;
                    if (take_wr) app_wdf_data <= mem_wr_data;
                    if (take_wr == last_wr)
                        burst_cnt <= (burst_cnt >= MAX_CNT) ? burst_cnt : burst_cnt + 8'd1;
                    else
                        burst_cnt <= 8'd1;
                end else begin
                    burst_cnt <= 8'd0;
                end
            end
            if (cmd_fire)  cmd_done  <= 1'b1;
            if (data_fire) data_done <= 1'b1;
            if (state == ACK) grant <= 2'b00;
        end
    end

endmodule

// File: tb/tb_mem_rd_wr_arbiter.sv
// Self-checking bench for mem_rd_wr_arbiter: per-cycle vector table for the
// basic read/write/tie flows, plus directed sequences for stall, re-request,
// contention fairness and asynchronous reset.
module tb_mem_rd_wr_arbiter;

    localparam int ADDR_W     = 29;
    localparam int DATA_W     = 256;
    localparam int MAX_BURSTS = 8;
    localparam logic [ADDR_W-1:0] WR_A = 29'h0000200;
    localparam logic [ADDR_W-1:0] RD_A = 29'h0000100;
    localparam logic [DATA_W-1:0] WR_D = {32{8'hA5}};

    logic                clk = 1'b0;
    logic                reset_clk_n;
    logic                mem_wr_req;
    logic [ADDR_W-1:0]   mem_wr_addr;
    logic [DATA_W-1:0]   mem_wr_data;
    logic                mem_wr_ack;
    logic                mem_rd_req;
    logic [ADDR_W-1:0]   mem_rd_addr;
    logic                mem_rd_ack;
    logic                app_en;
    logic [2:0]          app_cmd;
    logic [ADDR_W-1:0]   app_addr;
    logic                app_rdy;
    logic                app_wdf_wren;
    logic [DATA_W-1:0]   app_wdf_data;
    logic                app_wdf_end;
    logic [DATA_W/8-1:0] app_wdf_mask;
    logic                app_wdf_rdy;
    logic [1:0]          grant;

    mem_rd_wr_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURSTS(MAX_BURSTS)
    ) dut (
        .clk(clk), .reset_clk_n(reset_clk_n),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_ack(mem_wr_ack),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
        .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end),
        .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
        .grant(grant)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle stimulus and expected outputs.
    typedef struct {
        logic              wr_req, rd_req, rdy, wdf;
        logic              en;
        logic [2:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic              wren;
        logic [1:0]        gnt;
        logic              wa, ra;
    } vec_t;

    function automatic vec_t mk(logic wr_req, rd_req, rdy, wdf, en, logic [2:0] cmd,
                                logic [ADDR_W-1:0] addr, logic wren, logic [1:0] gnt,
                                logic wa, ra);
        vec_t v;
        v.wr_req = wr_req; v.rd_req = rd_req; v.rdy = rdy; v.wdf = wdf;
        v.en = en; v.cmd = cmd; v.addr = addr; v.wren = wren; v.gnt = gnt;
        v.wa = wa; v.ra = ra;
        return v;
    endfunction

    vec_t vecs [23];

    // Requesters must hold req until their ack; flag any early drop.
    logic wr_pend = 1'b0;
    logic rd_pend = 1'b0;
    always @(negedge clk) begin
        if (!reset_clk_n) begin
            wr_pend = 1'b0;
            rd_pend = 1'b0;
        end else begin
            if (wr_pend) check("wr_req_held", mem_wr_req, 1'b1);
            if (rd_pend) check("rd_req_held", mem_rd_req, 1'b1);
            wr_pend = mem_wr_req && !mem_wr_ack;
            rd_pend = mem_rd_req && !mem_rd_ack;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse starting mid-cycle; returns at the start of a fresh cycle.
    task automatic do_reset();
        reset_clk_n = 1'b0;
        #1;
        mem_wr_req = 1'b0;
        mem_rd_req = 1'b0;
        @(negedge clk);
        #2;
        reset_clk_n = 1'b1;
        next_cycle();
    endtask

    int            n_acks;
    int            cyc;
    int            fires;
    logic          seq [32];
    logic [ADDR_W-1:0] fire_addr [$];

    initial begin
        // Single read, skewed-ready write, split-order write, idle tie then queued write.
        vecs[0]  = mk(0,1,1,1, 0,3'd0,'0,  0,2'b00,0,0);
        vecs[1]  = mk(0,1,1,1, 1,3'd1,RD_A,0,2'b01,0,0);
        vecs[2]  = mk(0,1,1,1, 0,3'd0,'0,  0,2'b01,0,1);
        vecs[3]  = mk(0,0,1,1, 0,3'd0,'0,  0,2'b00,0,0);
        vecs[4]  = mk(1,0,1,0, 0,3'd0,'0,  0,2'b00,0,0);
        vecs[5]  = mk(1,0,1,0, 1,3'd0,WR_A,1,2'b10,0,0);
        vecs[6]  = mk(1,0,0,0, 0,3'd0,'0,  1,2'b10,0,0);
        vecs[7]  = mk(1,0,0,0, 0,3'd0,'0,  1,2'b10,0,0);
        vecs[8]  = mk(1,0,0,1, 0,3'd0,'0,  1,2'b10,0,0);
        vecs[9]  = mk(1,0,0,0, 0,3'd0,'0,  0,2'b10,1,0);
        vecs[10] = mk(0,0,0,0, 0,3'd0,'0,  0,2'b00,0,0);
        vecs[11] = mk(1,0,0,1, 0,3'd0,'0,  0,2'b00,0,0);
        vecs[12] = mk(1,0,0,1, 1,3'd0,WR_A,1,2'b10,0,0);
        vecs[13] = mk(1,0,1,0, 1,3'd0,WR_A,0,2'b10,0,0);
        vecs[14] = mk(1,0,0,0, 0,3'd0,'0,  0,2'b10,1,0);
        vecs[15] = mk(0,0,0,0, 0,3'd0,'0,  0,2'b00,0,0);
        vecs[16] = mk(1,1,1,1, 0,3'd0,'0,  0,2'b00,0,0);
        vecs[17] = mk(1,1,1,1, 1,3'd1,RD_A,0,2'b01,0,0);
        vecs[18] = mk(1,1,1,1, 0,3'd0,'0,  0,2'b01,0,1);
        vecs[19] = mk(1,0,1,1, 0,3'd0,'0,  0,2'b00,0,0);
        vecs[20] = mk(1,0,1,1, 1,3'd0,WR_A,1,2'b10,0,0);
        vecs[21] = mk(1,0,1,1, 0,3'd0,'0,  0,2'b10,1,0);
        vecs[22] = mk(0,0,1,1, 0,3'd0,'0,  0,2'b00,0,0);

        reset_clk_n = 1'b0;
        mem_wr_req  = 1'b0;
        mem_rd_req  = 1'b0;
        mem_wr_addr = WR_A;
        mem_rd_addr = RD_A;
        mem_wr_data = WR_D;
        app_rdy     = 1'b0;
        app_wdf_rdy = 1'b0;

        // Reset state.
        #12;
        check("rst app_en", app_en, 1'b0);
        check("rst wren", app_wdf_wren, 1'b0);
        check("rst wdf_end", app_wdf_end, 1'b0);
        check("rst grant", grant, 2'b00);
        check("rst wr_ack", mem_wr_ack, 1'b0);
        check("rst rd_ack", mem_rd_ack, 1'b0);
        check("rst app_cmd", app_cmd, 3'b000);
        check("rst app_addr", app_addr, '0);
        check("rst wdf_mask", app_wdf_mask, '0);
        #10;
        reset_clk_n = 1'b1;
        next_cycle();

        // Table-driven vectors.
        for (int i = 0; i < 23; i++) begin
            mem_wr_req  = vecs[i].wr_req;
            mem_rd_req  = vecs[i].rd_req;
            app_rdy     = vecs[i].rdy;
            app_wdf_rdy = vecs[i].wdf;
            @(negedge clk);
            check($sformatf("v%0d app_en", i), app_en, vecs[i].en);
            check($sformatf("v%0d wren", i), app_wdf_wren, vecs[i].wren);
            check($sformatf("v%0d wdf_end", i), app_wdf_end, vecs[i].wren);
            check($sformatf("v%0d grant", i), grant, vecs[i].gnt);
            check($sformatf("v%0d wr_ack", i), mem_wr_ack, vecs[i].wa);
            check($sformatf("v%0d rd_ack", i), mem_rd_ack, vecs[i].ra);
            check($sformatf("v%0d wdf_mask", i), app_wdf_mask, '0);
            if (vecs[i].en) begin
                check($sformatf("v%0d app_cmd", i), app_cmd, vecs[i].cmd);
                check($sformatf("v%0d app_addr", i), app_addr, vecs[i].addr);
            end
            if (vecs[i].wren) check($sformatf("v%0d wdf_data", i), app_wdf_data, WR_D);
            next_cycle();
        end

        // app_rdy stall for 20 cycles during a read command.
        mem_rd_addr = 29'h0ABCDEF;
        mem_rd_req  = 1'b1;
        app_rdy     = 1'b0;
        next_cycle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d app_en", i), app_en, 1'b1);
            check($sformatf("stall%0d app_addr", i), app_addr, 29'h0ABCDEF);
            check($sformatf("stall%0d app_cmd", i), app_cmd, 3'b001);
            check($sformatf("stall%0d grant", i), grant, 2'b01);
            check($sformatf("stall%0d rd_ack", i), mem_rd_ack, 1'b0);
            next_cycle();
        end
        app_rdy = 1'b1;
        @(negedge clk);
        check("stall release app_en", app_en, 1'b1);
        check("stall release rd_ack", mem_rd_ack, 1'b0);
        next_cycle();
        @(negedge clk);
        check("stall ack", mem_rd_ack, 1'b1);
        check("stall ack grant", grant, 2'b01);
        next_cycle();
        mem_rd_req = 1'b0;
        next_cycle();

        // Re-request with a new address the cycle after ack.
        fires = 0;
        n_acks = 0;
        mem_rd_addr = 29'h0001000;
        mem_rd_req  = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c == 3) mem_rd_addr = 29'h0002000;
            if (c == 6) mem_rd_req = 1'b0;
            @(negedge clk);
            if (app_en && app_rdy) begin
                fires++;
                fire_addr.push_back(app_addr);
            end
            if (mem_rd_ack) n_acks++;
            next_cycle();
        end
        check("rereq cmd count", fires, 2);
        check("rereq ack count", n_acks, 2);
        if (fires == 2) begin
            check("rereq first addr", fire_addr[0], 29'h0001000);
            check("rereq second addr", fire_addr[1], 29'h0002000);
        end

        // Contention from reset: 8 writes, 8 reads, alternating.
        do_reset();
        mem_wr_addr = WR_A;
        mem_rd_addr = RD_A;
        mem_wr_req  = 1'b1;
        mem_rd_req  = 1'b1;
        app_rdy     = 1'b1;
        app_wdf_rdy = 1'b1;
        n_acks = 0;
        cyc    = 0;
        while (n_acks < 32 && cyc < 200) begin
            @(negedge clk);
            if (mem_wr_ack || mem_rd_ack) begin
                check("cont ack onehot", mem_wr_ack & mem_rd_ack, 1'b0);
                seq[n_acks] = mem_wr_ack;
                n_acks++;
            end
            cyc++;
            next_cycle();
        end
        check("cont ack count", n_acks, 32);
        for (int i = 0; i < n_acks; i++)
            check($sformatf("cont ack%0d is_wr", i), seq[i], ((i / MAX_BURSTS) % 2) == 0);

        // Async reset in the middle of a write command.
        do_reset();
        mem_wr_addr = 29'h0000321;
        mem_wr_req  = 1'b1;
        app_rdy     = 1'b0;
        app_wdf_rdy = 1'b0;
        next_cycle();
        @(negedge clk);
        check("mid wr app_en", app_en, 1'b1);
        check("mid wr wren", app_wdf_wren, 1'b1);
        check("mid wr grant", grant, 2'b10);
        #2;
        reset_clk_n = 1'b0;
        #1;
        check("arst app_en", app_en, 1'b0);
        check("arst wren", app_wdf_wren, 1'b0);
        check("arst wdf_end", app_wdf_end, 1'b0);
        check("arst grant", grant, 2'b00);
        check("arst wr_ack", mem_wr_ack, 1'b0);
        check("arst rd_ack", mem_rd_ack, 1'b0);
        mem_wr_req = 1'b0;
        @(negedge clk);
        check("arst held app_en", app_en, 1'b0);
        #2;
        reset_clk_n = 1'b1;
        next_cycle();
        mem_wr_addr = WR_A;
        mem_wr_req  = 1'b1;
        mem_rd_req  = 1'b1;
        app_rdy     = 1'b1;
        app_wdf_rdy = 1'b1;
        @(negedge clk);
        check("post rst idle grant", grant, 2'b00);
        next_cycle();
        @(negedge clk);
        check("post rst tie grant", grant, 2'b10);
        check("post rst tie cmd", app_cmd, 3'b000);
        check("post rst tie addr", app_addr, WR_A);
        next_cycle();
        @(negedge clk);
        check("post rst wr_ack", mem_wr_ack, 1'b1);
        next_cycle();
        mem_wr_req = 1'b0;
        @(negedge clk);
        check("post rst arb grant", grant, 2'b00);
        next_cycle();
        @(negedge clk);
        check("post rst rd grant", grant, 2'b01);
        check("post rst rd addr", app_addr, RD_A);
        next_cycle();
        @(negedge clk);
        check("post rst rd_ack", mem_rd_ack, 1'b1);
        next_cycle();
        mem_rd_req = 1'b0;
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
